// File: rtl/fd_grad_pkg.sv
// rtl/fd_grad_pkg.sv - shared types, widths and saturating Q8.8 add for fd_grad_ctrl
// Build option: FD_GRAD_CENTRAL_DIFF_EN switches the evaluation count to central difference.
package fd_grad_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    REQ,
    WAIT_DONE,
    WAIT_REL,
    CALC,
    DONE
  } state_t;

`ifdef FD_GRAD_CENTRAL_DIFF_EN
  localparam int NUM_EVAL = 9;
`else
  localparam int NUM_EVAL = 5;
`endif

  localparam int Q88_W  = 16;
  localparam int Q248_W = 32;
  localparam int K_W    = 4;

  localparam logic signed [Q88_W-1:0]  Q88_MAX  = 16'sh7FFF;
  localparam logic signed [Q88_W-1:0]  Q88_MIN  = 16'sh8000;
  localparam logic signed [Q248_W-1:0] Q248_MAX = 32'sh7FFFFFFF;
  localparam logic signed [Q248_W-1:0] Q248_MIN = 32'sh80000000;

  // Returns {saturated, sum}.
  function automatic logic [Q88_W:0] q88_add_sat(input logic signed [Q88_W-1:0] x,
                                                 input logic signed [Q88_W-1:0] d);
    logic signed [Q88_W:0] s;
    s = 17'(x) + 17'(d);
    if (s > 17'sd32767) begin
      return {1'b1, Q88_MAX};
    end else if (s < -17'sd32768) begin
      return {1'b1, Q88_MIN};
    end
    return {1'b0, s[Q88_W-1:0]};
  endfunction

endpackage

// File: rtl/fd_grad_ctrl_sat_shift_diff.sv
// rtl/fd_grad_ctrl_sat_shift_diff.sv - 33-bit difference, arithmetic left shift, saturate to Q24.8
module sat_shift_diff
  import fd_grad_pkg::*;
#(
  parameter int SHIFT = 2
) (
  input  logic signed [Q248_W-1:0] z_p,
  input  logic signed [Q248_W-1:0] z_m,
  output logic signed [Q248_W-1:0] grad,
  output logic                     ovf
);

  localparam int DIFF_W = Q248_W + 1;
  localparam int WIDE_W = DIFF_W + SHIFT;

  logic signed [DIFF_W-1:0] diff;
  logic signed [WIDE_W-1:0] wide;

  assign diff = DIFF_W'(z_p) - DIFF_W'(z_m);
  assign wide = WIDE_W'(diff) <<< SHIFT;

  always_comb begin
    ovf  = 1'b0;
    grad = wide[Q248_W-1:0];
    if (wide > WIDE_W'(Q248_MAX)) begin
      grad = Q248_MAX;
      ovf  = 1'b1;
    end else if (wide < WIDE_W'(Q248_MIN)) begin
      grad = Q248_MIN;
      ovf  = 1'b1;
    end
  end

endmodule

// File: rtl/fd_grad_ctrl.sv
// rtl/fd_grad_ctrl.sv - finite-difference gradient sequencer driving the func evaluator
// Build option: FD_GRAD_CENTRAL_DIFF_EN selects central difference (9 evaluations).
module fd_grad_ctrl
  import fd_grad_pkg::*;
#(
  parameter int H_LOG2  = 6,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic signed [Q88_W-1:0]  a_in,
  input  logic signed [Q88_W-1:0]  b_in,
  input  logic signed [Q88_W-1:0]  c_in,
  input  logic signed [Q88_W-1:0]  d_in,
  output logic                     busy,
  output logic                     start_func,
  output logic signed [Q88_W-1:0]  fa,
  output logic signed [Q88_W-1:0]  fb,
  output logic signed [Q88_W-1:0]  fc,
  output logic signed [Q88_W-1:0]  fd,
  input  logic signed [Q248_W-1:0] z_in,
  input  logic                     func_done,
  input  logic                     func_ovf,
  output logic signed [Q248_W-1:0] f0_out,
  output logic signed [Q248_W-1:0] grad_a,
  output logic signed [Q248_W-1:0] grad_b,
  output logic signed [Q248_W-1:0] grad_c,
  output logic signed [Q248_W-1:0] grad_d,
  output logic                     done,
  output logic                     ovf,
  output logic                     timeout_err
);

`ifdef FD_GRAD_CENTRAL_DIFF_EN
  localparam int SHIFT = 7 - H_LOG2;
`else
  localparam int SHIFT = 8 - H_LOG2;
`endif
  localparam int TCNT_W = $clog2(TIMEOUT + 1);
  localparam logic signed [Q88_W-1:0] H_STEP = Q88_W'(1 << H_LOG2);
  localparam logic signed [Q88_W-1:0] H_NEG  = -H_STEP;

  state_t                   state, state_n;
  logic [K_W-1:0]           k;
  logic [TCNT_W-1:0]        tcnt;
  logic                     tmo;
  logic                     last_eval;
  logic signed [Q88_W-1:0]  pt  [4];
  logic signed [Q88_W-1:0]  nxt [4];
  logic                     nxt_sat;
  logic [Q88_W:0]           add_r;
  logic signed [Q248_W-1:0] z   [NUM_EVAL];
  logic signed [Q248_W-1:0] g   [4];
  logic [3:0]               g_ovf;

  assign tmo       = (tcnt == TCNT_W'(TIMEOUT - 1));
  assign last_eval = (k == K_W'(NUM_EVAL - 1));

  // Operand set for evaluation k: base point with at most one coordinate stepped.
  always_comb begin
    nxt_sat = 1'b0;
    add_r   = '0;
    for (int i = 0; i < 4; i++) nxt[i] = pt[i];
    for (int i = 0; i < 4; i++) begin
      if (k == K_W'(i + 1)) begin
        add_r   = q88_add_sat(pt[i], H_STEP);
        nxt[i]  = add_r[Q88_W-1:0];
        nxt_sat = add_r[Q88_W];
      end
`ifdef FD_GRAD_CENTRAL_DIFF_EN
      if (k == K_W'(i + 5)) begin
        add_r   = q88_add_sat(pt[i], H_NEG);
        nxt[i]  = add_r[Q88_W-1:0];
        nxt_sat = add_r[Q88_W];
      end
`endif
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_diff
    sat_shift_diff #(.SHIFT(SHIFT)) u_diff (
      .z_p  (z[i+1]),
`ifdef FD_GRAD_CENTRAL_DIFF_EN
      .z_m  (z[i+5]),
`else
      .z_m  (z[0]),
`endif
      .grad (g[i]),
      .ovf  (g_ovf[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n    = state;
    busy       = (state != IDLE);
    start_func = (state == REQ) || (state == WAIT_DONE);
    done       = (state == DONE);
    case (state)
      IDLE:      if (start) state_n = SETUP;
      SETUP:     state_n = REQ;
      REQ:       state_n = WAIT_DONE;
      WAIT_DONE: begin
        if (func_done)  state_n = WAIT_REL;
        else if (tmo)   state_n = DONE;
      end
      WAIT_REL:  begin
        if (!func_done) state_n = last_eval ? CALC : SETUP;
        else if (tmo)   state_n = DONE;
      end
      CALC:      state_n = DONE;
      DONE:      state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k           <= '0;
      tcnt        <= '0;
      ovf         <= 1'b0;
      timeout_err <= 1'b0;
      fa          <= '0;
      fb          <= '0;
      fc          <= '0;
      fd          <= '0;
      f0_out      <= '0;
      grad_a      <= '0;
      grad_b      <= '0;
      grad_c      <= '0;
      grad_d      <= '0;
      for (int i = 0; i < 4; i++) pt[i] <= '0;
      for (int i = 0; i < NUM_EVAL; i++) z[i] <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          pt[0]       <= a_in;
          pt[1]       <= b_in;
          pt[2]       <= c_in;
          pt[3]       <= d_in;
          ovf         <= 1'b0;
          timeout_err <= 1'b0;
          k           <= '0;
        end
        SETUP: begin
          fa <= nxt[0];
          fb <= nxt[1];
          fc <= nxt[2];
          fd <= nxt[3];
          if (nxt_sat) ovf <= 1'b1;
        end
        REQ: tcnt <= '0;
        WAIT_DONE: begin
          if (func_done) begin
            for (int i = 0; i < NUM_EVAL; i++) if (k == K_W'(i)) z[i] <= z_in;
            if (func_ovf) ovf <= 1'b1;
            tcnt <= '0;
          end else if (tmo) begin
            timeout_err <= 1'b1;
            grad_a      <= '0;
            grad_b      <= '0;
            grad_c      <= '0;
            grad_d      <= '0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        WAIT_REL: begin
          if (!func_done) begin
            if (!last_eval) k <= k + 1'b1;
          end else if (tmo) begin
            timeout_err <= 1'b1;
            grad_a      <= '0;
            grad_b      <= '0;
            grad_c      <= '0;
            grad_d      <= '0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        CALC: begin
          f0_out <= z[0];
          grad_a <= g[0];
          grad_b <= g[1];
          grad_c <= g[2];
          grad_d <= g[3];
          if (|g_ovf) ovf <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fd_grad_ctrl.sv
// tb/tb_fd_grad_ctrl.sv - self-checking bench for fd_grad_ctrl with a behavioural evaluator
module tb_fd_grad_ctrl;

  localparam int H_LOG2  = 6;
  localparam int TIMEOUT = 64;
`ifdef FD_GRAD_CENTRAL_DIFF_EN
  localparam int N_EVAL = 9;
  localparam int SH     = 7 - H_LOG2;
`else
  localparam int N_EVAL = 5;
  localparam int SH     = 8 - H_LOG2;
`endif
  localparam int     LAT      = N_EVAL * 11 + 2;
  localparam longint H        = longint'(1) << H_LOG2;
  localparam longint GMAX     = 64'sd2147483647;
  localparam longint GMIN     = -64'sd2147483648;
  localparam longint FOVF_LIM = 64'sd4194304;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [15:0] a_in, b_in, c_in, d_in;
  logic        busy, start_func;
  logic [15:0] fa, fb, fc, fd;
  logic [31:0] z_in;
  logic        func_done, func_ovf;
  logic [31:0] f0_out, grad_a, grad_b, grad_c, grad_d;
  logic        done, ovf, timeout_err;
  bit          stuck;

  always #5 clk = ~clk;

  fd_grad_ctrl #(.H_LOG2(H_LOG2), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a_in(a_in), .b_in(b_in), .c_in(c_in), .d_in(d_in),
    .busy(busy), .start_func(start_func),
    .fa(fa), .fb(fb), .fc(fc), .fd(fd),
    .z_in(z_in), .func_done(func_done), .func_ovf(func_ovf),
    .f0_out(f0_out), .grad_a(grad_a), .grad_b(grad_b), .grad_c(grad_c), .grad_d(grad_d),
    .done(done), .ovf(ovf), .timeout_err(timeout_err)
  );

  typedef struct {
    logic [31:0] f0;
    logic [31:0] g [4];
    logic        ovf;
    logic        tmo;
    int          lat;
  } exp_t;

  exp_t        exp_q[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] last_f0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_assert++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, want, $time);
    end
  endtask

  // Test function: (a-2)^2 + b^2 + (c+2)^2 + 4d^2 - 5, Q8.8 in, Q24.8 out.
  function automatic longint f4(input longint a, input longint b, input longint c, input longint d);
    return ((a - 512) * (a - 512) + b * b + (c + 512) * (c + 512) + 4 * d * d) / 256 - 1280;
  endfunction

  // Evaluator: done 6 cycles after start_func rises, released 2 cycles after it falls.
  int ev_cnt, ev_rel;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      func_done <= 1'b0;
      func_ovf  <= 1'b0;
      z_in      <= '0;
      ev_cnt    <= 0;
      ev_rel    <= 0;
    end else if (start_func) begin
      ev_rel <= 0;
      if (!func_done && !stuck) begin
        if (ev_cnt == 5) begin
          func_done <= 1'b1;
          z_in      <= 32'(f4(longint'($signed(fa)), longint'($signed(fb)),
                               longint'($signed(fc)), longint'($signed(fd))));
          func_ovf  <= (f4(longint'($signed(fa)), longint'($signed(fb)),
                           longint'($signed(fc)), longint'($signed(fd))) > FOVF_LIM);
        end else begin
          ev_cnt <= ev_cnt + 1;
        end
      end
    end else begin
      ev_cnt <= 0;
      if (func_done) begin
        if (ev_rel == 1) begin
          func_done <= 1'b0;
          ev_rel    <= 0;
        end else begin
          ev_rel <= ev_rel + 1;
        end
      end
    end
  end

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic [15:0] c, input logic [15:0] d);
    exp_t   e;
    longint p[4];
    longint q[4];
    longint z0, zp, zm, gv;
    p[0] = longint'($signed(a));
    p[1] = longint'($signed(b));
    p[2] = longint'($signed(c));
    p[3] = longint'($signed(d));
    e.ovf = 1'b0;
    e.tmo = 1'b0;
    e.lat = LAT;
    z0 = f4(p[0], p[1], p[2], p[3]);
    if (z0 > FOVF_LIM) e.ovf = 1'b1;
    for (int i = 0; i < 4; i++) begin
      q = p;
      q[i] = p[i] + H;
      if (q[i] > 32767) begin q[i] = 32767; e.ovf = 1'b1; end
      zp = f4(q[0], q[1], q[2], q[3]);
      if (zp > FOVF_LIM) e.ovf = 1'b1;
`ifdef FD_GRAD_CENTRAL_DIFF_EN
      q = p;
      q[i] = p[i] - H;
      if (q[i] < -32768) begin q[i] = -32768; e.ovf = 1'b1; end
      zm = f4(q[0], q[1], q[2], q[3]);
      if (zm > FOVF_LIM) e.ovf = 1'b1;
`else
      zm = z0;
`endif
      gv = (zp - zm) * (longint'(1) << SH);
      if (gv > GMAX) begin gv = GMAX; e.ovf = 1'b1; end
      else if (gv < GMIN) begin gv = GMIN; e.ovf = 1'b1; end
      e.g[i] = gv[31:0];
    end
    e.f0 = z0[31:0];
    return e;
  endfunction

  // Compare process: protocol every cycle, results against the model on every done.
  initial begin
    logic        prev_sf;
    logic [63:0] prev_ops;
    int          busy_cyc;
    exp_t        e;
    prev_sf  = 1'b0;
    prev_ops = '0;
    busy_cyc = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_sf  = 1'b0;
        busy_cyc = 0;
      end else begin
        if (busy) busy_cyc++;
        else busy_cyc = 0;
        if (start_func && !prev_sf) chk("sf_rise_while_func_done", func_done, 0);
        if (start_func && prev_sf) chk("operands_stable", {fa, fb, fc, fd}, prev_ops);
        if (done) begin
          if (exp_q.size() == 0) begin
            n_assert++;
            n_fail++;
            $display("FAIL unexpected_done: done=1, expected no done at %0t", $time);
          end else begin
            e = exp_q.pop_front();
            chk("f0_out", f0_out, e.f0);
            chk("grad_a", grad_a, e.g[0]);
            chk("grad_b", grad_b, e.g[1]);
            chk("grad_c", grad_c, e.g[2]);
            chk("grad_d", grad_d, e.g[3]);
            chk("ovf", ovf, e.ovf);
            chk("timeout_err", timeout_err, e.tmo);
            chk("latency", busy_cyc, e.lat);
          end
        end
        prev_sf  = start_func;
        prev_ops = {fa, fb, fc, fd};
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_start_func"}, start_func, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_ovf"}, ovf, 0);
    chk({tag, "_timeout_err"}, timeout_err, 0);
    chk({tag, "_f0"}, f0_out, 0);
    chk({tag, "_grads"}, {grad_a, grad_b, grad_c, grad_d}, 0);
    chk({tag, "_operands"}, {fa, fb, fc, fd}, 0);
  endtask

  task automatic launch(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] c, input logic [15:0] d);
    @(negedge clk);
    a_in  = a;
    b_in  = b;
    c_in  = c;
    d_in  = d;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int cyc);
    int n;
    n = 0;
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      n_assert++;
      n_fail++;
      $display("FAIL %s_no_done: waited %0d cycles, expected done", tag, n);
    end
    cyc = n + 1;
  endtask

  task automatic run(input string tag, input logic [15:0] a, input logic [15:0] b,
                     input logic [15:0] c, input logic [15:0] d, output int cyc);
    exp_t e;
    e = model(a, b, c, d);
    exp_q.push_back(e);
    last_f0 = e.f0;
    launch(a, b, c, d);
    wait_done(tag, cyc);
  endtask

  task automatic chk_zero_point_literals(input string tag, input int cyc);
    chk({tag, "_lit_f0"}, f0_out, 32'h00000300);
`ifdef FD_GRAD_CENTRAL_DIFF_EN
    chk({tag, "_lit_ga"}, grad_a, 32'hFFFFFC00);
    chk({tag, "_lit_gb"}, grad_b, 32'h00000000);
    chk({tag, "_lit_gc"}, grad_c, 32'h00000400);
    chk({tag, "_lit_gd"}, grad_d, 32'h00000000);
    chk({tag, "_lit_latency"}, cyc, 101);
`else
    chk({tag, "_lit_ga"}, grad_a, 32'hFFFFFC40);
    chk({tag, "_lit_gb"}, grad_b, 32'h00000040);
    chk({tag, "_lit_gc"}, grad_c, 32'h00000440);
    chk({tag, "_lit_gd"}, grad_d, 32'h00000100);
    chk({tag, "_lit_latency"}, cyc, 57);
`endif
    chk({tag, "_lit_ovf"}, ovf, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int   cyc, cnt, n, rises;
    logic sf_d;
    exp_t e;
    rst_n   = 1'b0;
    start   = 1'b0;
    a_in    = '0;
    b_in    = '0;
    c_in    = '0;
    d_in    = '0;
    stuck   = 1'b0;
    last_f0 = '0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

    run("zero", 16'h0000, 16'h0000, 16'h0000, 16'h0000, cyc);
    chk_zero_point_literals("zero", cyc);

    run("a_sat", 16'h7FF0, 16'h0000, 16'h0000, 16'h0000, cyc);
    chk("a_sat_lit_ovf", ovf, 1);
    run("mixed", 16'hFF00, 16'h0100, 16'hFE80, 16'h0040, cyc);
    run("b_low", 16'h0000, 16'h8010, 16'h0000, 16'h0000, cyc);
    run("func_ovf", 16'h8100, 16'h0000, 16'h0000, 16'h0000, cyc);
    chk("func_ovf_lit_ovf", ovf, 1);

    // Evaluator that never answers.
    stuck   = 1'b1;
    e.f0    = last_f0;
    for (int i = 0; i < 4; i++) e.g[i] = '0;
    e.ovf   = 1'b0;
    e.tmo   = 1'b1;
    e.lat   = TIMEOUT + 3;
    exp_q.push_back(e);
    launch(16'h0000, 16'h0000, 16'h0000, 16'h0000);
    wait_done("stuck", cyc);
    chk("stuck_lit_timeout_err", timeout_err, 1);
    chk("stuck_lit_start_func", start_func, 0);
    @(negedge clk);
    chk("stuck_busy_after", busy, 0);
    stuck = 1'b0;

    // start held high across three runs.
    for (int r = 0; r < 3; r++) begin
      e = model(16'h0100, 16'hFF80, 16'h0200, 16'hFFC0);
      exp_q.push_back(e);
      last_f0 = e.f0;
    end
    @(negedge clk);
    a_in  = 16'h0100;
    b_in  = 16'hFF80;
    c_in  = 16'h0200;
    d_in  = 16'hFFC0;
    start = 1'b1;
    cnt   = 0;
    n     = 0;
    while (cnt < 3 && n < LAT * 4) begin
      @(negedge clk);
      n++;
      if (done) cnt++;
    end
    start = 1'b0;
    chk("cont_done_count", cnt, 3);
    repeat (LAT + 10) @(negedge clk);
    chk("cont_queue_empty", exp_q.size(), 0);
    chk("cont_busy_idle", busy, 0);

    // Reset while waiting on evaluation k=2.
    e = model(16'h0000, 16'h0000, 16'h0000, 16'h0000);
    exp_q.push_back(e);
    launch(16'h0000, 16'h0000, 16'h0000, 16'h0000);
    rises = 1;
    sf_d  = 1'b0;
    n     = 0;
    rises = 0;
    while (rises < 3 && n < 200) begin
      @(negedge clk);
      n++;
      if (start_func && !sf_d) rises++;
      sf_d = start_func;
    end
    chk("reset_reach_k2", rises, 3);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("midrun_reset");
    exp_q.delete();
    last_f0 = '0;
    @(negedge clk);
    rst_n = 1'b1;

    run("fresh", 16'h0000, 16'h0000, 16'h0000, 16'h0000, cyc);
    chk_zero_point_literals("fresh", cyc);
    repeat (4) @(negedge clk);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
